// File: rtl/gf180mcu_fd_sc_mcu7t5v0__xnor_acc.sv
// Framed XOR/XNOR parity accumulator with a valid/ready beat input,
// a registered result output and a saturating, overflow-flagged beat count.
module gf180mcu_fd_sc_mcu7t5v0__xnor_acc #(
  parameter int WIDTH = 3,
  parameter int CNT_W = 4
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [WIDTH-1:0] A,
  input  logic             VALID_IN,
  input  logic             LAST_IN,
  input  logic             INV,
  output logic             READY_IN,
  output logic             ZN,
  output logic [CNT_W-1:0] COUNT,
  output logic             OVF,
  output logic             VALID_OUT,
  input  logic             READY_OUT
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic             s1_valid_q, s1_valid_d;
  logic             s1_p_q, s1_p_d;
  logic             s1_last_q, s1_last_d;
  logic             s1_inv_q, s1_inv_d;
  logic             acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ovf_q, ovf_d;
  logic             zn_q, zn_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             ovf_out_q, ovf_out_d;
  logic             vout_q, vout_d;

  logic             out_free;
  logic             s1_adv;
  logic             load;
  logic             accept;
  logic             sat;
  logic [CNT_W-1:0] cnt_inc;

  assign out_free = !vout_q || READY_OUT;
  // A non-last entry never waits; only a frame close needs the output slot.
  assign s1_adv   = s1_valid_q && (!s1_last_q || out_free);
  assign load     = s1_adv && s1_last_q;
  assign READY_IN = !RST && (!s1_valid_q || s1_adv);
  assign accept   = VALID_IN && READY_IN;
  assign sat      = (cnt_q == CNT_MAX);
  assign cnt_inc  = sat ? CNT_MAX : cnt_q + 1'b1;

  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_p_d     = s1_p_q;
    s1_last_d  = s1_last_q;
    s1_inv_d   = s1_inv_q;
    if (accept) begin
      s1_valid_d = 1'b1;
      s1_p_d     = ^A;
      s1_last_d  = LAST_IN;
      s1_inv_d   = INV;
    end else if (s1_adv) begin
      s1_valid_d = 1'b0;
    end
  end

  always_comb begin
    acc_d = acc_q;
    cnt_d = cnt_q;
    ovf_d = ovf_q;
    if (s1_adv) begin
      if (s1_last_q) begin
        acc_d = 1'b0;
        cnt_d = '0;
        ovf_d = 1'b0;
      end else begin
        acc_d = acc_q ^ s1_p_q;
        cnt_d = cnt_inc;
        ovf_d = ovf_q | sat;
      end
    end
  end

  always_comb begin
    zn_d      = zn_q;
    count_d   = count_q;
    ovf_out_d = ovf_out_q;
    vout_d    = vout_q;
    if (load) begin
      zn_d      = acc_q ^ s1_p_q ^ s1_inv_q;
      count_d   = cnt_inc;
      ovf_out_d = ovf_q | sat;
      vout_d    = 1'b1;
    end else if (READY_OUT) begin
      vout_d = 1'b0;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      s1_valid_q <= 1'b0;
      s1_p_q     <= 1'b0;
      s1_last_q  <= 1'b0;
      s1_inv_q   <= 1'b0;
      acc_q      <= 1'b0;
      cnt_q      <= '0;
      ovf_q      <= 1'b0;
      zn_q       <= 1'b0;
      count_q    <= '0;
      ovf_out_q  <= 1'b0;
      vout_q     <= 1'b0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_p_q     <= s1_p_d;
      s1_last_q  <= s1_last_d;
      s1_inv_q   <= s1_inv_d;
      acc_q      <= acc_d;
      cnt_q      <= cnt_d;
      ovf_q      <= ovf_d;
      zn_q       <= zn_d;
      count_q    <= count_d;
      ovf_out_q  <= ovf_out_d;
      vout_q     <= vout_d;
    end
  end

  assign ZN        = zn_q;
  assign COUNT     = count_q;
  assign OVF       = ovf_out_q;
  assign VALID_OUT = vout_q;

endmodule

// File: tb/tb_gf180mcu_fd_sc_mcu7t5v0__xnor_acc.sv
// Bench for the XNOR accumulator: frame-level scoreboard model plus
// directed vectors, run on a CNT_W=4 and a CNT_W=2 instance in parallel.
module tb_gf180mcu_fd_sc_mcu7t5v0__xnor_acc;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic [2:0] A = '0;
  logic       VALID_IN = 1'b0;
  logic       LAST_IN = 1'b0;
  logic       INV = 1'b0;
  logic       READY_OUT = 1'b1;

  logic       rdy_d, zn_d, ovf_d, vo_d;
  logic [3:0] cnt_d;
  logic       rdy_s, zn_s, ovf_s, vo_s;
  logic [1:0] cnt_s;

  int total = 0;
  int bad = 0;

  gf180mcu_fd_sc_mcu7t5v0__xnor_acc #(.WIDTH(3), .CNT_W(4)) u_d (
    .CLK(CLK), .RST(RST), .A(A), .VALID_IN(VALID_IN),
    .LAST_IN(LAST_IN), .INV(INV), .READY_IN(rdy_d), .ZN(zn_d),
    .COUNT(cnt_d), .OVF(ovf_d), .VALID_OUT(vo_d),
    .READY_OUT(READY_OUT)
  );

  gf180mcu_fd_sc_mcu7t5v0__xnor_acc #(.WIDTH(3), .CNT_W(2)) u_s (
    .CLK(CLK), .RST(RST), .A(A), .VALID_IN(VALID_IN),
    .LAST_IN(LAST_IN), .INV(INV), .READY_IN(rdy_s), .ZN(zn_s),
    .COUNT(cnt_s), .OVF(ovf_s), .VALID_OUT(vo_s),
    .READY_OUT(READY_OUT)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string nm, input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, got, exp, $time);
    end
  endtask

  // Frame-level model: results are parity of all accepted beats of a
  // frame, and the block can hold at most two closed frames unconsumed.
  typedef struct {bit zn; int n;} res_t;
  res_t q[$];
  res_t e;
  int   pending = 0;
  bit   f_par = 0;
  int   f_n = 0;
  int   popped = 0;
  bit   exp_rdy;

  function automatic int sat_cnt(input int n, input int m);
    return (n > m) ? m : n;
  endfunction

  always @(negedge CLK) begin
    exp_rdy = !RST && !(pending == 2 && !READY_OUT);
    chk("ready_in_w4", rdy_d, exp_rdy);
    chk("ready_in_w2", rdy_s, exp_rdy);
    if (vo_d || vo_s) begin
      chk("result_pending", q.size() > 0, 1);
      if (q.size() > 0) begin
        e = q[0];
        chk("vout_w4", vo_d, 1);
        chk("vout_w2", vo_s, 1);
        chk("zn_w4", zn_d, e.zn);
        chk("zn_w2", zn_s, e.zn);
        chk("count_w4", cnt_d, sat_cnt(e.n, 15));
        chk("count_w2", cnt_s, sat_cnt(e.n, 3));
        chk("ovf_w4", ovf_d, e.n > 15);
        chk("ovf_w2", ovf_s, e.n > 3);
      end
    end
    if (RST) begin
      q.delete();
      pending = 0;
      f_par = 0;
      f_n = 0;
    end else begin
      if (vo_d && READY_OUT && q.size() > 0) begin
        void'(q.pop_front());
        pending--;
        popped++;
      end
      if (VALID_IN && exp_rdy) begin
        f_par ^= ^A;
        f_n++;
        if (LAST_IN) begin
          q.push_back('{f_par ^ INV, f_n});
          pending++;
          f_par = 0;
          f_n = 0;
        end
      end
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge CLK);
      #1;
    end
  endtask

  task automatic send(input logic [2:0] a, input logic last,
                      input logic inv, output int tries);
    logic r;
    A = a;
    LAST_IN = last;
    INV = inv;
    VALID_IN = 1'b1;
    tries = 0;
    do begin
      @(negedge CLK);
      r = rdy_d;
      @(posedge CLK);
      #1;
      tries++;
    end while (!r && tries < 20);
    chk("send_accept", r, 1);
  endtask

  task automatic idle();
    VALID_IN = 1'b0;
    LAST_IN = 1'b0;
  endtask

  task automatic wait_res(input string nm, input logic zn,
                          input int cd, input logic od,
                          input int cs, input logic os);
    int k;
    k = 0;
    do begin
      @(negedge CLK);
      k++;
    end while (!vo_d && k < 10);
    chk({nm, "_valid"}, vo_d, 1);
    chk({nm, "_zn"}, zn_d, zn);
    chk({nm, "_cnt_w4"}, cnt_d, cd);
    chk({nm, "_ovf_w4"}, ovf_d, od);
    chk({nm, "_cnt_w2"}, cnt_s, cs);
    chk({nm, "_ovf_w2"}, ovf_s, os);
    @(posedge CLK);
    #1;
  endtask

  logic [7:0] xnor_tab = 8'b01101001;
  int t, t2, p0;

  initial begin
    @(negedge CLK);
    chk("rst_ready", rdy_d, 0);
    step(2);
    RST = 1'b0;
    @(negedge CLK);
    chk("rst_vout", vo_d, 0);
    chk("rst_zn", zn_d, 0);
    chk("rst_count", cnt_d, 0);
    chk("rst_ovf", ovf_d, 0);
    chk("rst_ready_after", rdy_d, 1);
    @(posedge CLK);
    #1;

    // latency: driven after edge t, result visible after edge t+2
    send(3'b101, 1'b1, 1'b1, t);
    idle();
    @(negedge CLK);
    chk("lat_early", vo_d, 0);
    @(negedge CLK);
    chk("lat_vout", vo_d, 1);
    chk("lat_zn", zn_d, 1);
    chk("lat_count", cnt_d, 1);
    chk("lat_ovf", ovf_d, 0);
    @(posedge CLK);
    #1;

    for (int a = 0; a < 8; a++) begin
      send(3'(a), 1'b1, 1'b1, t);
      idle();
      wait_res("xnor_sweep", xnor_tab[a], 1, 0, 1, 0);
    end

    send(3'b001, 1'b0, 1'b0, t);
    send(3'b011, 1'b0, 1'b0, t);
    send(3'b111, 1'b1, 1'b0, t);
    idle();
    wait_res("three_xor", 0, 3, 0, 3, 0);
    send(3'b001, 1'b0, 1'b1, t);
    send(3'b011, 1'b0, 1'b1, t);
    send(3'b111, 1'b1, 1'b1, t);
    idle();
    wait_res("three_xnor", 1, 3, 0, 3, 0);

    repeat (3) send(3'b001, 1'b0, 1'b0, t);
    send(3'b001, 1'b1, 1'b0, t);
    idle();
    wait_res("four_beat", 0, 4, 0, 3, 1);
    repeat (4) send(3'b001, 1'b0, 1'b0, t);
    send(3'b001, 1'b1, 1'b0, t);
    idle();
    wait_res("five_beat", 1, 5, 0, 3, 1);
    send(3'b000, 1'b1, 1'b0, t);
    idle();
    wait_res("after_ovf", 0, 1, 0, 1, 0);

    READY_OUT = 1'b0;
    send(3'b111, 1'b1, 1'b0, t);
    send(3'b011, 1'b1, 1'b0, t2);
    idle();
    chk("bp_second_tries", t2, 1);
    repeat (3) begin
      @(negedge CLK);
      chk("bp_ready", rdy_d, 0);
      chk("bp_hold_vout", vo_d, 1);
      chk("bp_hold_zn", zn_d, 1);
      chk("bp_hold_cnt", cnt_d, 1);
      @(posedge CLK);
      #1;
    end
    READY_OUT = 1'b1;
    @(negedge CLK);
    chk("bp_first_zn", zn_d, 1);
    @(posedge CLK);
    #1;
    @(negedge CLK);
    chk("bp_second_vout", vo_d, 1);
    chk("bp_second_zn", zn_d, 0);
    @(posedge CLK);
    #1;
    step(1);

    send(3'b001, 1'b0, 1'b0, t);
    send(3'b010, 1'b0, 1'b0, t);
    idle();
    RST = 1'b1;
    step(1);
    RST = 1'b0;
    send(3'b110, 1'b1, 1'b1, t);
    idle();
    wait_res("rst_mid", 1, 1, 0, 1, 0);

    p0 = popped;
    for (int i = 0; i < 8; i++) begin
      send(3'(i), 1'b1, i[0], t);
      chk("b2b_tries", t, 1);
    end
    idle();
    step(3);
    chk("b2b_results", popped - p0, 8);

    step(3);
    chk("queue_empty", q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule
